// File: rtl/incr_pkg.sv
// Shared types and default constants for the incrementer sequencer.
package incr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_STEPS_W  = 5;
  localparam int DEF_DIV_W    = 4;
  localparam int MIN_INTERVAL = 1;

endpackage

// File: rtl/incr_sequencer_if.sv
// Control/status bundle between a run controller (master) and the sequencer (slave).
interface incr_sequencer_if
  import incr_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STEPS_W = DEF_STEPS_W,
  parameter int DIV_W   = DEF_DIV_W
);

  logic               go;
  logic [WIDTH-1:0]   start_val;
  logic [STEPS_W-1:0] num_steps;
  logic [DIV_W-1:0]   interval;
  logic               hold;
  logic               abort;
  logic [WIDTH-1:0]   current;
  logic [STEPS_W-1:0] step_cnt;
  logic               busy;
  logic               done;

  modport master (
    output go, start_val, num_steps, interval, hold, abort,
    input  current, step_cnt, busy, done
  );

  modport slave (
    input  go, start_val, num_steps, interval, hold, abort,
    output current, step_cnt, busy, done
  );

endinterface

// File: rtl/incr_tick_div.sv
// Cycles-per-step divider: tick marks the enabled cycle on which the count reaches ivl-1.
module incr_tick_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] ivl,
  output logic             tick
);

  logic [DIV_W-1:0] count_reg;

  assign tick = en && (count_reg == (ivl - DIV_W'(1)));

  // A disabled cycle (hold/abort) leaves the count untouched, so stalls shift later ticks.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/incr_sequencer.sv
// Start/done controller that loads a value and applies N increments, one every ivl cycles.
module incr_sequencer
  import incr_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STEPS_W = DEF_STEPS_W,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  incr_sequencer_if.slave  bus
);

  state_t             state_reg;
  logic [WIDTH-1:0]   current_reg;
  logic [STEPS_W-1:0] step_cnt_reg;
  logic [STEPS_W-1:0] nsteps_reg;
  logic [DIV_W-1:0]   ivl_reg;

  logic accept_go;
  logic run_en;
  logic tick;
  logic last_step;

  assign accept_go = (state_reg == IDLE) && bus.go;
  // abort takes priority: it also blocks the increment due in the same cycle.
  assign run_en    = (state_reg == RUN) && !bus.hold && !bus.abort;
  assign last_step = (step_cnt_reg + STEPS_W'(1)) == nsteps_reg;

  incr_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_go),
    .en   (run_en),
    .ivl  (ivl_reg),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      current_reg  <= '0;
      step_cnt_reg <= '0;
      nsteps_reg   <= '0;
      ivl_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.go) begin
            current_reg  <= bus.start_val;
            step_cnt_reg <= '0;
            nsteps_reg   <= bus.num_steps;
            ivl_reg      <= (bus.interval == '0) ? DIV_W'(MIN_INTERVAL) : bus.interval;
            state_reg    <= (bus.num_steps != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_reg <= IDLE;
          end else if (tick) begin
            current_reg  <= current_reg + WIDTH'(1);
            step_cnt_reg <= step_cnt_reg + STEPS_W'(1);
            if (last_step) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.current  = current_reg;
  assign bus.step_cnt = step_cnt_reg;
  assign bus.busy     = (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);

endmodule

// File: tb/tb_incr_sequencer.sv
// Directed bench for incr_sequencer: table-driven runs plus hold/abort/reset sequences.
module tb_incr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  incr_sequencer_if bus ();

  incr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int start_val;
    int num_steps;
    int interval;
    int exp_current;
    int exp_busy_cycles;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_go(input int sv, input int ns, input int iv);
    bus.start_val = 4'(sv);
    bus.num_steps = 5'(ns);
    bus.interval  = 4'(iv);
    bus.go        = 1'b1;
    step();
    bus.go        = 1'b0;
  endtask

  // Drives one full run and checks every cycle against the arithmetic model.
  task automatic run_vec(input vec_t v);
    int ivl;
    int m;
    int inc;
    ivl = (v.interval == 0) ? 1 : v.interval;
    issue_go(v.start_val, v.num_steps, v.interval);
    for (m = 0; m <= v.exp_busy_cycles + 1; m++) begin
      inc = m / ivl;
      if (inc > v.num_steps) inc = v.num_steps;
      chk("trace_current", int'(bus.current), (v.start_val + inc) % 16);
      chk("trace_step_cnt", int'(bus.step_cnt), inc);
      chk("trace_busy", int'(bus.busy), (m < v.exp_busy_cycles) ? 1 : 0);
      chk("trace_done", int'(bus.done), (m == v.exp_busy_cycles) ? 1 : 0);
      if (m == v.exp_busy_cycles) begin
        chk("final_current", int'(bus.current), v.exp_current);
        chk("final_step_cnt", int'(bus.step_cnt), v.num_steps);
      end
      if (m <= v.exp_busy_cycles + 1) step();
    end
    $display("run start=%0d steps=%0d interval=%0d -> current=%0d step_cnt=%0d",
             v.start_val, v.num_steps, v.interval, bus.current, bus.step_cnt);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{start_val: 0,  num_steps: 16, interval: 1,  exp_current: 0, exp_busy_cycles: 16};
    vecs[1] = '{start_val: 3,  num_steps: 5,  interval: 10, exp_current: 8, exp_busy_cycles: 50};
    vecs[2] = '{start_val: 9,  num_steps: 0,  interval: 5,  exp_current: 9, exp_busy_cycles: 0};
    vecs[3] = '{start_val: 5,  num_steps: 3,  interval: 0,  exp_current: 8, exp_busy_cycles: 3};
    vecs[4] = '{start_val: 5,  num_steps: 3,  interval: 1,  exp_current: 8, exp_busy_cycles: 3};
    vecs[5] = '{start_val: 14, num_steps: 4,  interval: 1,  exp_current: 2, exp_busy_cycles: 4};
    vecs[6] = '{start_val: 7,  num_steps: 31, interval: 1,  exp_current: 6, exp_busy_cycles: 31};

    bus.go = 1'b0; bus.start_val = '0; bus.num_steps = '0; bus.interval = '0;
    bus.hold = 1'b0; bus.abort = 1'b0;

    // Reset state; hold/abort/go-inputs toggling during reset must not matter.
    bus.abort = 1'b1;
    step(); step();
    bus.abort = 1'b0;
    rst = 1'b0;
    step();
    chk("reset_current", int'(bus.current), 0);
    chk("reset_step_cnt", int'(bus.step_cnt), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    $display("reset: current=%0d step_cnt=%0d busy=%0d done=%0d",
             bus.current, bus.step_cnt, bus.busy, bus.done);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Hold for 3 cycles after the first increment: later increments slip by 3.
    issue_go(0, 4, 2);
    step(); step();
    chk("hold_first_inc", int'(bus.current), 1);
    bus.hold = 1'b1;
    step(); step(); step();
    chk("hold_frozen_current", int'(bus.current), 1);
    chk("hold_frozen_step", int'(bus.step_cnt), 1);
    chk("hold_busy", int'(bus.busy), 1);
    bus.hold = 1'b0;
    step();
    chk("hold_after_release", int'(bus.current), 1);
    step();
    chk("hold_second_inc", int'(bus.current), 2);
    step(); step(); step();
    chk("hold_not_done_yet", int'(bus.done), 0);
    chk("hold_before_last", int'(bus.current), 3);
    step();
    chk("hold_done", int'(bus.done), 1);
    chk("hold_final_current", int'(bus.current), 4);
    chk("hold_final_step", int'(bus.step_cnt), 4);
    step();
    chk("hold_idle_busy", int'(bus.busy), 0);
    $display("hold run -> current=%0d step_cnt=%0d", bus.current, bus.step_cnt);

    // Abort after 2 increments, with a go pulsed mid-run that must be ignored.
    issue_go(5, 8, 1);
    step();
    chk("abort_inc1", int'(bus.current), 6);
    bus.go = 1'b1; bus.start_val = 4'd12; bus.num_steps = 5'd1;
    step();
    bus.go = 1'b0;
    chk("ignored_go_current", int'(bus.current), 7);
    chk("ignored_go_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_current", int'(bus.current), 7);
    chk("abort_step_cnt", int'(bus.step_cnt), 2);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_no_done", int'(bus.done), 0);
    for (int k = 0; k < 3; k++) begin
      bus.hold = 1'b1;
      step();
      chk("abort_idle_done", int'(bus.done), 0);
      chk("abort_idle_current", int'(bus.current), 7);
    end
    bus.hold = 1'b0;
    $display("abort run -> current=%0d step_cnt=%0d", bus.current, bus.step_cnt);

    // Reset at step 3 of 10, then a clean restart.
    issue_go(0, 10, 1);
    step(); step(); step();
    chk("rst_pre_current", int'(bus.current), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_current", int'(bus.current), 0);
    chk("rst_step_cnt", int'(bus.step_cnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    $display("mid-run reset -> current=%0d step_cnt=%0d", bus.current, bus.step_cnt);
    run_vec('{start_val: 1, num_steps: 2, interval: 3, exp_current: 3, exp_busy_cycles: 6});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/incr_sequencer.md
Name: incr_sequencer

Overview:
- Clocked controller for the 4-bit incrementer datapath.
- Loads a start value and applies a programmed number of +1 steps, one step every programmed number of clock cycles.
- Reports busy while running and pulses done when finished.
- Replaces the free-running, delay-driven counting loop, so test benches and upper-level FSMs can start, stall and abort a counting run under a start/done handshake.

Parameters:
- WIDTH, 4, width of the counted value (current, start_val).
- STEPS_W, 5, width of the step-count fields (up to 31 steps; 16 = one full wrap at WIDTH=4).
- DIV_W, 4, width of the interval field (cycles per step).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- start_val  in  WIDTH  initial value loaded on accepted go.
- num_steps  in  STEPS_W  number of increments to apply; captured on accepted go.
- interval  in  DIV_W  cycles per increment; captured on accepted go; 0 is treated as 1.
- hold  in  1  stall; freezes the tick counter and current while high in RUN.
- abort  in  1  cancel the run; effective in RUN only.
- current  out  WIDTH  counted value (registered).
- step_cnt  out  STEPS_W  increments applied so far in this run (registered).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse marking run completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, current=0, step_cnt=0, busy=0, done=0, tick counter=0, captured num_steps and interval=0.
- States: IDLE, RUN, DONE. busy=(state==RUN) and done=(state==DONE), both decoded from registered state.
- IDLE, go=1 at edge E: current<=start_val, step_cnt<=0, tick<=0, capture num_steps and interval (ivl = interval==0 ? 1 : interval).
  - Next state is RUN if num_steps!=0, otherwise DONE (current=start_val, no increments).
- RUN, hold=0:
  - If tick==ivl-1: tick<=0, current<=current+1 (mod 2^WIDTH, silent wrap 15->0), step_cnt<=step_cnt+1.
  - Otherwise tick<=tick+1.
- RUN, hold=1: tick, current and step_cnt all frozen. Each held cycle delays every later edge by exactly one cycle.
- Completion: on the edge that applies increment number num_steps, state<=DONE. Increments land at edges E+ivl, E+2*ivl, …, E+N*ivl (no hold). done is high in the single cycle after edge E+N*ivl, with the final current already visible.
- DONE: state<=IDLE unconditionally on the next edge. current and step_cnt keep their final values until the next accepted go.
- abort in RUN, checked before the increment logic: state<=IDLE and no increment that cycle. No done pulse. current and step_cnt hold their partial values.
- Ignored inputs:
  - go in RUN or DONE is ignored and not queued.
  - abort in IDLE or DONE has no effect.
  - hold outside RUN has no effect.
- Simultaneous inputs in RUN: abort wins over hold and over an increment due that cycle.
- rst mid-run: rst overrides everything at the next edge and returns all state to reset values. No done pulse.
- Inputs start_val, num_steps and interval are don't-care outside the go cycle.

Decomposition:
- Package incr_pkg:
  - State typedef {IDLE, RUN, DONE}.
  - Default constants WIDTH=4, STEPS_W=5, DIV_W=4.
  - Constant MIN_INTERVAL=1.
- One sub-module, incr_tick_div: DIV_W tick counter with inputs clr, en, ivl and output tick (high when count==ivl-1 and en).
  - The FSM, value register and step counter stay in incr_sequencer.

Test Plan:
- Basic run: start_val=0, num_steps=16, interval=1, go one cycle.
  - current steps 1..15 then 0 on consecutive edges; busy high for 16 cycles.
  - done for 1 cycle with current=0, step_cnt=16.
- Slow interval: start_val=3, num_steps=5, interval=10.
  - Increments exactly at go-edge+10, +20, …, +50; done in the cycle after +50 with current=8.
- Hold: start_val=0, num_steps=4, interval=2, hold high for 3 cycles after the first increment.
  - current frozen at 1 during hold; final increment delayed by 3 cycles; done with current=4.
- Abort and ignored go:
  - Abort after 2 increments (start 5, 8 steps, interval 1): current=7, step_cnt=2, busy=0 next cycle, done never asserted.
  - A go pulsed during RUN changes nothing.
- Zero and edge cases:
  - num_steps=0, start_val=9: done pulses the cycle after go, current=9, busy never high.
  - interval=0 behaves identically to interval=1.
- Reset mid-run: rst at step 3 of 10.
  - Next cycle current=0, step_cnt=0, busy=0, done=0.
  - A subsequent go starts cleanly.
